// File: rtl/tile_fetch_arbiter.sv
// tile_fetch_arbiter
//   Round-robin arbiter that collects one tile-row request per layer and serves
//   them over a single toggle-handshake graphics ROM port. Blank tiles are
//   answered with zero data and never touch the ROM. Row data can be reversed
//   pixel-by-pixel on the way out for X-flip.
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   ch_req       per-channel one-cycle request pulse
//   ch_code      tile codes, channel i at [i*CODE_W +: CODE_W]
//   ch_row       rows within tile, channel i at [i*ROW_W +: ROW_W]
//   ch_yflip     per-channel row inversion
//   ch_xflip     per-channel pixel-order reversal on load
//   ch_load      one-hot one-cycle pulse marking load_data valid for a channel
//   load_data    tile row data, held until the next load
//   rom_address  {code, row, zero padding}
//   rom_req      toggles once per ROM access
//   rom_ack      equals rom_req when the access is complete
//   rom_data     valid when rom_ack == rom_req
//   busy         ROM access in flight
//   overrun      sticky per channel: request replaced a still-pending one
module tile_fetch_arbiter #(
  parameter int unsigned       CHANNELS   = 4,
  parameter int unsigned       CODE_W     = 16,
  parameter int unsigned       ROW_W      = 4,
  parameter int unsigned       ADDR_W     = 23,
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       PIX_W      = 4,
  parameter logic [CODE_W-1:0] BLANK_MASK = 16'h7fff
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CHANNELS-1:0]        ch_req,
  input  logic [CHANNELS*CODE_W-1:0] ch_code,
  input  logic [CHANNELS*ROW_W-1:0]  ch_row,
  input  logic [CHANNELS-1:0]        ch_yflip,
  input  logic [CHANNELS-1:0]        ch_xflip,
  output logic [CHANNELS-1:0]        ch_load,
  output logic [DATA_W-1:0]          load_data,
  output logic [ADDR_W-1:0]          rom_address,
  output logic                       rom_req,
  input  logic                       rom_ack,
  input  logic [DATA_W-1:0]          rom_data,
  output logic                       busy,
  output logic [CHANNELS-1:0]        overrun
);

  localparam int unsigned PTR_W = $clog2(CHANNELS);
  localparam int unsigned PAD   = ADDR_W - CODE_W - ROW_W;
  localparam int unsigned NGRP  = DATA_W / PIX_W;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] overrun_q, overrun_d;
  logic [CHANNELS-1:0] ch_load_q, ch_load_d;
  logic [CODE_W-1:0]   slot_code_q [CHANNELS];
  logic [CODE_W-1:0]   slot_code_d [CHANNELS];
  logic [ROW_W-1:0]    slot_row_q  [CHANNELS];
  logic [ROW_W-1:0]    slot_row_d  [CHANNELS];
  logic [CHANNELS-1:0] slot_yflip_q, slot_yflip_d;
  logic [CHANNELS-1:0] slot_xflip_q, slot_xflip_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    cur_q, cur_d;
  logic                cur_xflip_q, cur_xflip_d;
  logic                rom_req_q, rom_req_d;
  logic [ADDR_W-1:0]   rom_address_q, rom_address_d;
  logic [DATA_W-1:0]   load_data_q, load_data_d;

  logic                found;
  logic [PTR_W-1:0]    sel;
  logic [CHANNELS-1:0] grant_oh;
  logic                sel_blank;
  logic [ROW_W-1:0]    sel_row;
  logic [DATA_W-1:0]   rom_data_rev;

  // First pending channel at or after rr_ptr, wrapping modulo CHANNELS so a
  // non-power-of-two channel count never selects a nonexistent slot.
  always_comb begin
    int unsigned idx;
    found    = 1'b0;
    sel      = '0;
    grant_oh = '0;
    idx      = 0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
    if (found && state_q == S_IDLE) grant_oh[sel] = 1'b1;
  end

  assign sel_blank = (slot_code_q[sel] & BLANK_MASK) == '0;
  assign sel_row   = slot_row_q[sel] ^ {ROW_W{slot_yflip_q[sel]}};

  always_comb begin
    rom_data_rev = '0;
    for (int unsigned g = 0; g < NGRP; g++)
      rom_data_rev[g*PIX_W +: PIX_W] = rom_data[(NGRP-1-g)*PIX_W +: PIX_W];
  end

  always_comb begin
    state_d       = state_q;
    overrun_d     = overrun_q;
    ch_load_d     = '0;
    slot_code_d   = slot_code_q;
    slot_row_d    = slot_row_q;
    slot_yflip_d  = slot_yflip_q;
    slot_xflip_d  = slot_xflip_q;
    rr_ptr_d      = rr_ptr_q;
    cur_d         = cur_q;
    cur_xflip_d   = cur_xflip_q;
    rom_req_d     = rom_req_q;
    rom_address_d = rom_address_q;
    load_data_d   = load_data_q;

    // Grant clears first so a same-cycle request on the granted channel
    // re-arms pending without counting as an overrun.
    pending_d = pending_q & ~grant_oh;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (ch_req[i]) begin
        slot_code_d[i]  = ch_code[i*CODE_W +: CODE_W];
        slot_row_d[i]   = ch_row[i*ROW_W +: ROW_W];
        slot_yflip_d[i] = ch_yflip[i];
        slot_xflip_d[i] = ch_xflip[i];
        pending_d[i]    = 1'b1;
        if (pending_q[i] && !grant_oh[i]) overrun_d[i] = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          if (sel_blank) begin
            load_data_d = '0;
            ch_load_d   = grant_oh;
            rr_ptr_d    = (sel == PTR_W'(CHANNELS-1)) ? '0 : sel + 1'b1;
          end else begin
            rom_address_d = ADDR_W'({slot_code_q[sel], sel_row}) << PAD;
            rom_req_d     = ~rom_req_q;
            cur_d         = sel;
            cur_xflip_d   = slot_xflip_q[sel];
            state_d       = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (rom_ack == rom_req_q) begin
          load_data_d      = cur_xflip_q ? rom_data_rev : rom_data;
          ch_load_d[cur_q] = 1'b1;
          rr_ptr_d         = (cur_q == PTR_W'(CHANNELS-1)) ? '0 : cur_q + 1'b1;
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pending_q     <= '0;
      overrun_q     <= '0;
      ch_load_q     <= '0;
      slot_yflip_q  <= '0;
      slot_xflip_q  <= '0;
      rr_ptr_q      <= '0;
      cur_q         <= '0;
      cur_xflip_q   <= 1'b0;
      rom_req_q     <= 1'b0;
      rom_address_q <= '0;
      load_data_q   <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        slot_code_q[i] <= '0;
        slot_row_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      ch_load_q     <= ch_load_d;
      slot_yflip_q  <= slot_yflip_d;
      slot_xflip_q  <= slot_xflip_d;
      rr_ptr_q      <= rr_ptr_d;
      cur_q         <= cur_d;
      cur_xflip_q   <= cur_xflip_d;
      rom_req_q     <= rom_req_d;
      rom_address_q <= rom_address_d;
      load_data_q   <= load_data_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        slot_code_q[i] <= slot_code_d[i];
        slot_row_q[i]  <= slot_row_d[i];
      end
    end
  end

  assign ch_load     = ch_load_q;
  assign load_data   = load_data_q;
  assign rom_address = rom_address_q;
  assign rom_req     = rom_req_q;
  assign busy        = (state_q == S_WAIT);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_tile_fetch_arbiter.sv
// Directed bench for tile_fetch_arbiter: the bench plays the layer sequencers
// and the ROM controller. Inputs change and outputs are sampled on negedge.
module tb_tile_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ch_req;
  logic [63:0] ch_code;
  logic [15:0] ch_row;
  logic [3:0]  ch_yflip;
  logic [3:0]  ch_xflip;
  logic [3:0]  ch_load;
  logic [63:0] load_data;
  logic [22:0] rom_address;
  logic        rom_req;
  logic        rom_ack;
  logic [63:0] rom_data;
  logic        busy;
  logic [3:0]  overrun;

  int errors = 0;
  int checks = 0;
  logic exp_req = 1'b0;

  tile_fetch_arbiter #(
    .CHANNELS(4), .CODE_W(16), .ROW_W(4), .ADDR_W(23),
    .DATA_W(64), .PIX_W(4), .BLANK_MASK(16'h7fff)
  ) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_code(ch_code),
    .ch_row(ch_row), .ch_yflip(ch_yflip), .ch_xflip(ch_xflip),
    .ch_load(ch_load), .load_data(load_data), .rom_address(rom_address),
    .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_req(input int c, input logic [15:0] code, input logic [3:0] row,
                         input logic yf, input logic xf);
    ch_req[c]         = 1'b1;
    ch_code[c*16 +: 16] = code;
    ch_row[c*4 +: 4]  = row;
    ch_yflip[c]       = yf;
    ch_xflip[c]       = xf;
  endtask

  task automatic clr_req;
    ch_req = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1; rom_ack = 1'b0; rom_data = '0; clr_req;
    ch_code = '0; ch_row = '0; ch_yflip = '0; ch_xflip = '0;
    tick; tick;
    checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL reset_rom_req: got %b want 0", rom_req); end
    checks++; if (rom_address !== 23'h0) begin errors++; $display("FAIL reset_rom_address: got %h want 0", rom_address); end
    checks++; if (ch_load !== 4'b0000) begin errors++; $display("FAIL reset_ch_load: got %b want 0000", ch_load); end
    checks++; if (load_data !== 64'h0) begin errors++; $display("FAIL reset_load_data: got %h want 0", load_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL reset_overrun: got %b want 0000", overrun); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single;
    set_req(2, 16'h0123, 4'h5, 1'b0, 1'b0);
    tick; clr_req;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_early: got %b want 0", busy); end
    tick;
    exp_req = ~exp_req;
    checks++; if (rom_req !== exp_req) begin errors++; $display("FAIL single_toggle: got %b want %b", rom_req, exp_req); end
    checks++; if (rom_address !== 23'h0091a8) begin errors++; $display("FAIL single_address: got %h want 0091a8", rom_address); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    tick; tick; tick;
    checks++; if (ch_load !== 4'b0000) begin errors++; $display("FAIL single_no_early_load: got %b want 0000", ch_load); end
    rom_data = 64'h1122334455667788; rom_ack = exp_req;
    tick;
    checks++; if (ch_load !== 4'b0100) begin errors++; $display("FAIL single_load: got %b want 0100", ch_load); end
    checks++; if (load_data !== 64'h1122334455667788) begin errors++; $display("FAIL single_data: got %h want 1122334455667788", load_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done: got %b want 0", busy); end
    checks++; if (rom_req !== exp_req) begin errors++; $display("FAIL single_one_toggle: got %b want %b", rom_req, exp_req); end
    tick;
    checks++; if (ch_load !== 4'b0000) begin errors++; $display("FAIL single_pulse: got %b want 0000", ch_load); end
    checks++; if (load_data !== 64'h1122334455667788) begin errors++; $display("FAIL single_hold: got %h want 1122334455667788", load_data); end
  endtask

  task automatic test_flips;
    set_req(0, 16'h0001, 4'h2, 1'b1, 1'b1);
    tick; clr_req;
    tick;
    exp_req = ~exp_req;
    checks++; if (rom_address !== 23'h0000e8) begin errors++; $display("FAIL flip_address: got %h want 0000e8", rom_address); end
    rom_data = 64'h0123456789abcdef; rom_ack = exp_req;
    tick;
    checks++; if (ch_load !== 4'b0001) begin errors++; $display("FAIL flip_load: got %b want 0001", ch_load); end
    checks++; if (load_data !== 64'hfedcba9876543210) begin errors++; $display("FAIL flip_data: got %h want fedcba9876543210", load_data); end
    tick;
  endtask

  task automatic test_blank;
    set_req(3, 16'h8000, 4'h7, 1'b0, 1'b0);
    tick; clr_req;
    checks++; if (ch_load !== 4'b0000) begin errors++; $display("FAIL blank_early: got %b want 0000", ch_load); end
    tick;
    checks++; if (ch_load !== 4'b1000) begin errors++; $display("FAIL blank_load: got %b want 1000", ch_load); end
    checks++; if (load_data !== 64'h0) begin errors++; $display("FAIL blank_data: got %h want 0", load_data); end
    checks++; if (rom_req !== exp_req) begin errors++; $display("FAIL blank_no_toggle: got %b want %b", rom_req, exp_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL blank_busy: got %b want 0", busy); end
    tick;
    checks++; if (ch_load !== 4'b0000) begin errors++; $display("FAIL blank_pulse: got %b want 0000", ch_load); end
  endtask

  task automatic test_round_robin;
    int order [4] = '{2, 3, 0, 1};
    logic [3:0] exp_oh;
    // A blank grant on channel 1 leaves the pointer at 2.
    set_req(1, 16'h0000, 4'h0, 1'b0, 1'b0);
    tick; clr_req; tick; tick;
    for (int c = 0; c < 4; c++) set_req(c, 16'h8000, 4'h0, 1'b0, 1'b0);
    tick; clr_req;
    for (int k = 0; k < 8; k++) begin
      tick; clr_req;
      exp_oh = 4'b0001 << order[k % 4];
      checks++; if (ch_load !== exp_oh) begin errors++; $display("FAIL rr_grant_%0d: got %b want %b", k, ch_load, exp_oh); end
      if (k < 4) set_req(order[k], 16'h8000, 4'h0, 1'b0, 1'b0);
    end
    tick;
    checks++; if (ch_load !== 4'b0000) begin errors++; $display("FAIL rr_idle: got %b want 0000", ch_load); end
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL rr_overrun: got %b want 0000", overrun); end
  endtask

  task automatic test_overrun;
    set_req(0, 16'h0010, 4'h0, 1'b0, 1'b0);
    tick; clr_req;
    tick;
    exp_req = ~exp_req;
    checks++; if (rom_address !== 23'h000800) begin errors++; $display("FAIL ovr_ch0_address: got %h want 000800", rom_address); end
    set_req(1, 16'h0aaa, 4'h1, 1'b0, 1'b0);
    tick;
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_first_req: got %b want 0000", overrun); end
    set_req(1, 16'h0bbb, 4'h2, 1'b0, 1'b0);
    tick; clr_req;
    checks++; if (overrun !== 4'b0010) begin errors++; $display("FAIL ovr_flag: got %b want 0010", overrun); end
    rom_data = 64'hdeadbeef00000001; rom_ack = exp_req;
    tick;
    checks++; if (ch_load !== 4'b0001) begin errors++; $display("FAIL ovr_ch0_load: got %b want 0001", ch_load); end
    tick;
    exp_req = ~exp_req;
    checks++; if (rom_req !== exp_req) begin errors++; $display("FAIL ovr_ch1_toggle: got %b want %b", rom_req, exp_req); end
    checks++; if (rom_address !== 23'h05dd90) begin errors++; $display("FAIL ovr_ch1_address: got %h want 05dd90", rom_address); end
    rom_data = 64'h00000000cafef00d; rom_ack = exp_req;
    tick;
    checks++; if (ch_load !== 4'b0010) begin errors++; $display("FAIL ovr_ch1_load: got %b want 0010", ch_load); end
    checks++; if (overrun !== 4'b0010) begin errors++; $display("FAIL ovr_sticky: got %b want 0010", overrun); end
    reset = 1'b1; rom_ack = 1'b0; exp_req = 1'b0;
    tick;
    reset = 1'b0;
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_reset_clear: got %b want 0000", overrun); end
    tick;
  endtask

  task automatic test_reset_mid_wait;
    set_req(3, 16'h0042, 4'h0, 1'b0, 1'b0);
    tick; clr_req;
    tick;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    checks++; if (rom_req !== 1'b1) begin errors++; $display("FAIL midrst_toggle: got %b want 1", rom_req); end
    reset = 1'b1; rom_ack = 1'b0;
    tick;
    reset = 1'b0; exp_req = 1'b0;
    checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL midrst_rom_req: got %b want 0", rom_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (ch_load !== 4'b0000) begin errors++; $display("FAIL midrst_ch_load: got %b want 0000", ch_load); end
    rom_data = 64'hbadbadbadbadbad0;
    for (int k = 0; k < 5; k++) begin
      tick;
      checks++; if (ch_load !== 4'b0000 || busy !== 1'b0) begin
        errors++; $display("FAIL midrst_stale_%0d: ch_load %b busy %b want 0000 0", k, ch_load, busy);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_flips;
    test_blank;
    test_round_robin;
    test_overrun;
    test_reset_mid_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
